dense_sequencer: RTL and testbench

Controller for the `densing` datapath in the pool_nl module; it sequences one dense-layer dot product of programmable length.
- It splits the vector into 9-element chunks and meters weight and activation streams into the filter and line buffers with valid/ready handshakes.
- It fires the MAC once per chunk with the correct `dense_valid` mask, then sums the per-chunk MAC results into a wide accumulator.
- It presents the final sum on a result handshake.

---
 rtl/dense_pkg.sv | 22 ++
 rtl/dense_sequencer.sv | 144 ++++++++++++++
 tb/tb_dense_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dense_pkg.sv
// Shared types and constants for the dense-layer dot-product sequencer.
// Latency: none (package only).
// Backpressure: none (package only).
package dense_pkg;

    // Elements consumed per MAC firing (one 3x3 window worth of lanes)
    localparam int CHUNK         = 9;
    // Default accumulator width for the dot-product result
    localparam int DEFAULT_ACC_W = 32;
    // Width of the per-chunk word counters; must hold the value CHUNK
    localparam int CNT_W         = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_LOAD,
        ST_FIRE,
        ST_DRAIN,
        ST_RESULT
    } dense_state_t;

endpackage

// File: rtl/dense_sequencer.sv
// Sequences one dense-layer dot product as 9-element chunks through the MAC and accumulates the result.
// Latency: 2 + ceil(N/9)*(10+MAC_LAT) cycles from cfg_start to res_valid with both streams always valid.
// Backpressure: wt/act streams stall independently via *_ready; result is held until res_ready.
module dense_sequencer
    import dense_pkg::*;
#(
    parameter int LEN_W       = 16,
    parameter int ACC_W       = DEFAULT_ACC_W,
    parameter int MAC_LAT     = 2,
    parameter int ADDR_FIFO   = 4,
    parameter int WID_PE_BITS = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_start,
    input  logic [LEN_W-1:0]              cfg_len,
    output logic                          busy,
    input  logic                          wt_valid,
    output logic                          wt_ready,
    input  logic                          act_valid,
    output logic                          act_ready,
    output logic                          shifting_filter,
    output logic                          shifting_line,
    output logic                          line_buffer_reset,
    output logic [ADDR_FIFO-1:0]          row_length,
    output logic [7:0]                    dense_valid,
    output logic                          mac_enable,
    input  logic signed [WID_PE_BITS-1:0] mac_result,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic signed [ACC_W-1:0]       res_data
);

    // The drain counter only has to reach MAC_LAT-1
    localparam int LAT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    dense_state_t     state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] acnt_q, acnt_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [LEN_W-1:0] chunk_len;

    // Ready depends only on state and counters so upstream never sees a valid->ready loop
    assign busy            = (state_q != ST_IDLE);
    assign wt_ready        = (state_q == ST_LOAD) && (wcnt_q < CNT_W'(CHUNK));
    assign act_ready       = (state_q == ST_LOAD) && (acnt_q < CNT_W'(CHUNK));
    assign shifting_filter = wt_valid & wt_ready;
    assign shifting_line   = act_valid & act_ready;
    assign row_length      = ADDR_FIFO'(CHUNK);
    assign res_valid       = (state_q == ST_RESULT);
    assign res_data        = acc_q;
    assign chunk_len       = (rem_q < LEN_W'(CHUNK)) ? rem_q : LEN_W'(CHUNK);

    // Next-state, counter and strobe logic for the chunk sequencing FSM
    always_comb begin
        state_d           = state_q;
        rem_d             = rem_q;
        acc_d             = acc_q;
        wcnt_d            = wcnt_q;
        acnt_d            = acnt_q;
        lat_d             = lat_q;
        line_buffer_reset = 1'b0;
        mac_enable        = 1'b0;
        dense_valid       = 8'd0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start && (cfg_len != '0)) begin
                    rem_d   = cfg_len;
                    acc_d   = '0;
                    wcnt_d  = '0;
                    acnt_d  = '0;
                    lat_d   = '0;
                    state_d = ST_CLR;
                end
            end
            ST_CLR: begin
                line_buffer_reset = 1'b1;
                state_d           = ST_LOAD;
            end
            ST_LOAD: begin
                if (shifting_filter) begin
                    wcnt_d = wcnt_q + 1'b1;
                end
                if (shifting_line) begin
                    acnt_d = acnt_q + 1'b1;
                end
                // Look at the post-transfer counts so the 9th word leads straight into FIRE
                if ((wcnt_d == CNT_W'(CHUNK)) && (acnt_d == CNT_W'(CHUNK))) begin
                    state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                mac_enable  = 1'b1;
                dense_valid = 8'(chunk_len);
                rem_d       = rem_q - chunk_len;
                wcnt_d      = '0;
                acnt_d      = '0;
                lat_d       = '0;
                state_d     = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (lat_q == LAT_W'(MAC_LAT - 1)) begin
                    // mac_result is signed; the size cast sign-extends, and the add wraps
                    acc_d   = acc_q + ACC_W'(mac_result);
                    lat_d   = '0;
                    state_d = (rem_q != '0) ? ST_LOAD : ST_RESULT;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and accumulator; reset aborts any run without emitting a result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            acc_q   <= '0;
            wcnt_q  <= '0;
            acnt_q  <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            wcnt_q  <= wcnt_d;
            acnt_q  <= acnt_d;
            lat_q   <= lat_d;
        end
    end

endmodule

// File: tb/tb_dense_sequencer.sv
// Self-checking bench for dense_sequencer: plays filter/line buffers and a MAC around the DUT.
// Latency: checks the cfg_start -> res_valid cycle count for fully-valid streams.
// Backpressure: random/toggled stream valids and delayed res_ready.
module tb_dense_sequencer;
    import dense_pkg::*;

    localparam int LEN_W       = 16;
    localparam int ACC_W       = 32;
    localparam int MAC_LAT     = 2;
    localparam int ADDR_FIFO   = 4;
    localparam int WID_PE_BITS = 16;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic                          cfg_start = 1'b0;
    logic [LEN_W-1:0]              cfg_len = '0;
    logic                          busy;
    logic                          wt_valid = 1'b0;
    logic                          wt_ready;
    logic                          act_valid = 1'b0;
    logic                          act_ready;
    logic                          shifting_filter;
    logic                          shifting_line;
    logic                          line_buffer_reset;
    logic [ADDR_FIFO-1:0]          row_length;
    logic [7:0]                    dense_valid;
    logic                          mac_enable;
    logic signed [WID_PE_BITS-1:0] mac_result = '0;
    logic                          res_valid;
    logic                          res_ready = 1'b0;
    logic signed [ACC_W-1:0]       res_data;

    dense_sequencer #(
        .LEN_W      (LEN_W),
        .ACC_W      (ACC_W),
        .MAC_LAT    (MAC_LAT),
        .ADDR_FIFO  (ADDR_FIFO),
        .WID_PE_BITS(WID_PE_BITS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_start        (cfg_start),
        .cfg_len          (cfg_len),
        .busy             (busy),
        .wt_valid         (wt_valid),
        .wt_ready         (wt_ready),
        .act_valid        (act_valid),
        .act_ready        (act_ready),
        .shifting_filter  (shifting_filter),
        .shifting_line    (shifting_line),
        .line_buffer_reset(line_buffer_reset),
        .row_length       (row_length),
        .dense_valid      (dense_valid),
        .mac_enable       (mac_enable),
        .mac_result       (mac_result),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int wv[72];
    int av[72];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d required %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_wt_ready"},  wt_ready, 0);
        check({tag, "_act_ready"}, act_ready, 0);
        check({tag, "_shf"},       shifting_filter, 0);
        check({tag, "_shl"},       shifting_line, 0);
        check({tag, "_lbr"},       line_buffer_reset, 0);
        check({tag, "_mac_en"},    mac_enable, 0);
        check({tag, "_res_vld"},   res_valid, 0);
        check({tag, "_dv"},        dense_valid, 0);
        check({tag, "_res_data"},  res_data, 0);
        check({tag, "_row_len"},   row_length, 9);
    endtask

    // Reference dot product over the first n elements, wrapped to the accumulator width
    function automatic longint exp_dot(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += wv[i] * av[i];
        return longint'(s);
    endfunction

    task automatic fill_rand();
        for (int i = 0; i < 72; i++) begin
            wv[i] = int'($urandom_range(15)) - 8;
            av[i] = int'($urandom_range(15)) - 8;
        end
    endtask

    // One job: play both buffers and the MAC, then check result, latency and chunk masks
    task automatic run_job(input int n, input int wpct, input int apct, input bit act_tog,
                           input int rdelay, input bit chk_lat, input bit poke, input int abort_at);
        int wi = 0, ai = 0, wcm = 0, acm = 0, fires = 0, fire_cyc = -1000;
        int start_cyc = 0, lbr_cnt = 0, lbr_cyc = -1, hold = 0, nch, dv, exp_dv;
        int wbuf[9];
        int abuf[9];
        longint pending = 0;
        longint acc_exp;
        logic [63:0] held = '0;
        bit seen = 0, done = 0, aborting = 0;
        nch = (n + 8) / 9;
        acc_exp = exp_dot(n);
        @(negedge clk);
        #1;
        check("idle_before_start", busy, 0);
        cfg_len = LEN_W'(n);
        cfg_start = 1'b1;
        start_cyc = cyc;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            cfg_start = 1'b0;
            if (aborting) begin
                wt_valid = 1'b0;
                act_valid = 1'b0;
                rst = 1'b0;
                #1;
                check_reset("abort");
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            wt_valid   = ($urandom_range(99) < wpct);
            act_valid  = act_tog ? (cyc % 2 == 0) : ($urandom_range(99) < apct);
            mac_result = (cyc == fire_cyc + MAC_LAT) ? 16'(pending) : 16'($urandom);
            res_ready  = (hold >= rdelay);
            #1;
            check("shift_filter", shifting_filter, wt_valid & wt_ready);
            check("shift_line", shifting_line, act_valid & act_ready);
            if (wt_ready)  check("wt_ready_below_9", (wcm < 9), 1);
            if (act_ready) check("act_ready_below_9", (acm < 9), 1);
            if (shifting_filter) begin
                if (wcm < 9 && wi < 72) wbuf[wcm] = wv[wi];
                wi++;
                wcm++;
            end
            if (shifting_line) begin
                if (acm < 9 && ai < 72) abuf[acm] = av[ai];
                ai++;
                acm++;
            end
            if (line_buffer_reset) begin
                lbr_cnt++;
                lbr_cyc = cyc;
            end
            if (mac_enable) begin
                exp_dv = (n - 9 * fires < 9) ? n - 9 * fires : 9;
                check("fire_dense_valid", dense_valid, exp_dv);
                check("fire_w_count", wcm, 9);
                check("fire_a_count", acm, 9);
                dv = (int'(dense_valid) > 9) ? 9 : int'(dense_valid);
                pending = 0;
                for (int j = 0; j < dv; j++) pending += wbuf[j] * abuf[j];
                fire_cyc = cyc;
                fires++;
                wcm = 0;
                acm = 0;
                if (abort_at != 0 && fires == abort_at) aborting = 1;
            end else begin
                check("dense_valid_idle", dense_valid, 0);
            end
            if (res_valid) begin
                if (!seen) begin
                    seen = 1;
                    held = res_data;
                    check("result", res_data, acc_exp);
                    if (chk_lat) check("latency", cyc - start_cyc, 2 + nch * (10 + MAC_LAT));
                end else begin
                    check("res_hold", res_data, held);
                end
                if (res_ready) begin
                    done = 1;
                end else begin
                    hold++;
                    if (poke && hold == 2) begin
                        cfg_len = 5;
                        cfg_start = 1'b1;
                    end
                end
            end
        end
        check("job_complete", done, 1);
        @(negedge clk);
        cfg_start = 1'b0;
        res_ready = 1'b0;
        wt_valid  = 1'b0;
        act_valid = 1'b0;
        #1;
        check("idle_after_result", busy, 0);
        check("res_valid_dropped", res_valid, 0);
        check("fire_count", fires, nch);
        check("lbr_count", lbr_cnt, 1);
        check("lbr_cycle", lbr_cyc - start_cyc, 1);
        @(negedge clk);
        #1;
        check("still_idle", busy, 0);
    endtask

    initial begin
        #1 rst = 1'b0;
        #2;
        check_reset("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // weights 1..9, activations 2 -> 90
        for (int i = 0; i < 72; i++) begin
            wv[i] = (i < 9) ? i + 1 : 0;
            av[i] = (i < 9) ? 2 : 0;
        end
        run_job(9, 100, 100, 0, 0, 1, 0, 0);

        // N=20 of ones with zero padding -> 20 across chunks 9,9,2
        for (int i = 0; i < 72; i++) begin
            wv[i] = (i < 20) ? 1 : 0;
            av[i] = (i < 20) ? 1 : 0;
        end
        run_job(20, 100, 100, 0, 0, 1, 0, 0);

        // activation valid toggling while weights are always valid
        fill_rand();
        run_job(9, 100, 0, 1, 0, 0, 0, 0);

        // delayed res_ready with a start pulse during RESULT
        fill_rand();
        run_job(9, 100, 100, 0, 5, 1, 1, 0);

        // zero-length start is ignored
        @(negedge clk);
        cfg_len = '0;
        cfg_start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cfg_start = 1'b0;
            #1;
            check("len0_busy", busy, 0);
        end

        // negative product: -3 * 4 -> -12
        fill_rand();
        wv[0] = -3;
        av[0] = 4;
        run_job(1, 100, 100, 0, 0, 1, 0, 0);

        // reset during DRAIN of chunk 2, then a clean run
        fill_rand();
        run_job(27, 100, 100, 0, 0, 0, 0, 2);
        fill_rand();
        run_job(9, 100, 100, 0, 0, 1, 0, 0);

        // randomized lengths and stream gaps
        for (int k = 0; k < 6; k++) begin
            fill_rand();
            run_job(int'($urandom_range(60, 1)), int'($urandom_range(100, 40)),
                    int'($urandom_range(100, 40)), 0, int'($urandom_range(3)), 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
